avmm_mem_responder: RTL and testbench
=====================================

Name: avmm_mem_responder

Overview:
- Avalon-MM slave (responder) modelling a small word-addressed memory behind the SDRAM-style master interface: active-low read_n/write_n, waitrequest, pipelined readdatavalid.
- Sits on the master's bus in place of the SDRAM controller, for bring-up and simulation.
- Provides fixed-latency pipelined reads, byte-enabled writes, pending-read throttling, and protocol/range error flagging.

Parameters:
- ADDR_W, 8: word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 16: data width; must be a multiple of 8.
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid; legal range 1..8.
- MAX_PENDING, 4: maximum reads accepted but not yet returned; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: synchronous, active-low.
- chipselect  in  1  slave select.
- read_n  in  1  read request, active-low.
- write_n  in  1  write request, active-low.
- address  in  32  word address.
- byteenable  in  DATA_W/8  write byte lanes.
- writedata  in  DATA_W  write data.
- waitrequest  out  1  stall; request not accepted this cycle.
- readdatavalid  out  1  readdata valid this cycle.
- readdata  out  DATA_W  read response.
- rd_count  out  16  accepted reads; saturates at 16'hFFFF.
- wr_count  out  16  accepted writes; saturates at 16'hFFFF.
- err  out  1  sticky error flag.

Behaviour:
- Reset values (reset_n low at clk edge): waitrequest 0, readdatavalid 0, readdata 0, rd_count 0, wr_count 0, err 0, pending 0, read pipeline cleared.
- Memory contents are not reset.
- Request decode:
  - rd_req = chipselect & ~read_n
  - wr_req = chipselect & ~write_n
  - A request is accepted at the clk edge ending a cycle in which it is present and waitrequest is 0.
- Simultaneous rd_req and wr_req: treated as a write only; err set.
- Range check: address[31:ADDR_W] nonzero is out of range.
  - Out-of-range write: accepted, memory unchanged, err set.
  - Out-of-range read: accepted, returns 16'hDEAD (low DATA_W bits of 32'h0000DEAD), err set.
- Writes: never stalled. Each byte lane i with byteenable[i]=1 is updated at the acceptance edge; other lanes are held. A read presented in any later cycle sees the new data.
- Reads:
  - Read accepted at end of cycle c: readdatavalid=1 and readdata=mem[address] (value as of the acceptance edge) during exactly cycle c+READ_LATENCY.
  - Returns are in order. Read pipeline is a valid/data shift register of READ_LATENCY stages.
- Pending counter (0..MAX_PENDING):
  - +1 on each read acceptance; -1 at the end of each readdatavalid cycle.
  - Both in the same cycle: unchanged.
- waitrequest = (pending == MAX_PENDING) & ~readdatavalid. Registered sources only; no combinational path from bus inputs.
  - MAX_PENDING >= READ_LATENCY gives one read per cycle.
- waitrequest applies to reads only. Writes presented while waitrequest=1 are still accepted.
- readdata is 0 whenever readdatavalid=0.
- Counters: rd_count and wr_count increment on acceptance and hold at 16'hFFFF.
- err clears only on reset.
- Reset mid-operation: all in-flight reads are discarded; no readdatavalid pulse follows reset.

Optional Feature:
- MEM_INIT_PATTERN_EN defined:
  - After reset_n deasserts, an INIT state walks the memory for 2^ADDR_W cycles, writing mem[i] = i zero-extended to DATA_W.
  - During INIT, waitrequest=1 for all requests, including writes.
  - Returns to RUN when the walk completes.
  - Reset during INIT restarts the walk.
- MEM_INIT_PATTERN_EN undefined: no INIT state; memory starts uninitialised; waitrequest governed only by the pending rule.

Test Plan:
- Write 16'hBEEF to address 3 with byteenable 2'b11, then read 3 (READ_LATENCY=2) -> readdatavalid high exactly 2 cycles after acceptance with readdata 16'hBEEF; wr_count=1, rd_count=1.
- With address 3 holding 16'hBEEF, write 16'h1234 with byteenable 2'b01, then read 3 -> readdata 16'hBE34.
- READ_LATENCY=2, MAX_PENDING=2; read_n held low for addresses 0..9 on consecutive cycles -> waitrequest never 1; 10 consecutive readdatavalid pulses returning mem[0..9] in order; rd_count=10.
- READ_LATENCY=3, MAX_PENDING=1; continuous reads -> waitrequest high 2 of every 3 cycles; one acceptance every 3 cycles, each coinciding with a readdatavalid cycle.
- Read address 32'h00000100 -> readdata 16'hDEAD, err=1.
- Write 16'h5555 to address 32'h00000100 -> memory unchanged (address 0 still reads its prior value).
- Assert reset_n=0 with 2 reads in flight -> no readdatavalid afterwards; all counters 0, err 0.
- With MEM_INIT_PATTERN_EN: waitrequest=1 for 256 cycles after reset; then read 9 -> 16'h0009.

Source files
------------

// File: rtl/avmm_mem_responder_if.sv
// Avalon-MM bus bundle for avmm_mem_responder: active-low read_n/write_n,
// waitrequest stall and pipelined readdatavalid return.
interface avmm_mem_responder_if #(
  parameter int DATA_W = 16
);
  logic                chipselect;
  logic                read_n;
  logic                write_n;
  logic [31:0]         address;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic                readdatavalid;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output chipselect, read_n, write_n, address, byteenable, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  chipselect, read_n, write_n, address, byteenable, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/avmm_mem_responder.sv
// Avalon-MM memory responder: fixed-latency pipelined reads, byte-enabled writes,
// pending-read throttling and sticky error flag. Optional MEM_INIT_PATTERN_EN fills mem[i]=i after reset.
module avmm_mem_responder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avmm_mem_responder_if.slave  bus,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic                 err
);

  localparam int          BE_W     = DATA_W / 8;
  localparam logic [31:0] OOR_WORD = 32'h0000_DEAD;
  localparam logic [3:0]  PEND_MAX = 4'(MAX_PENDING);

  logic [DATA_W-1:0]       mem [2**ADDR_W];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_W-1:0]       pipe_dat [READ_LATENCY];
  logic [3:0]              pending;
  logic                    init_busy;
  logic                    rd_req, wr_req, rd_acc, wr_acc, in_range;
  logic [ADDR_W-1:0]       word_addr;
  logic [DATA_W-1:0]       rd_word;

`ifdef MEM_INIT_PATTERN_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] init_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else if (state == ST_INIT) begin
      init_addr <= init_addr + 1'b1;
      if (&init_addr) state <= ST_RUN;
    end
  end

  assign init_busy = (state == ST_INIT);
`else
  assign init_busy = 1'b0;
`endif

  assign rd_req    = bus.chipselect & ~bus.read_n;
  assign wr_req    = bus.chipselect & ~bus.write_n;
  assign word_addr = bus.address[ADDR_W-1:0];
  assign in_range  = (bus.address >> ADDR_W) == '0;
  // A simultaneous read+write is a write; the read half is dropped.
  assign wr_acc    = wr_req & ~init_busy;
  assign rd_acc    = rd_req & ~wr_req & ~bus.waitrequest;
  assign rd_word   = in_range ? mem[word_addr] : DATA_W'(OOR_WORD);

  // Stall decision depends only on registered state, never on bus inputs.
  assign bus.waitrequest   = init_busy | ((pending == PEND_MAX) & ~bus.readdatavalid);
  assign bus.readdatavalid = pipe_vld[READ_LATENCY-1];
  assign bus.readdata      = pipe_dat[READ_LATENCY-1];

  always_ff @(posedge clk) begin
`ifdef MEM_INIT_PATTERN_EN
    if (reset_n && init_busy) mem[init_addr] <= DATA_W'(init_addr);
`endif
    if (reset_n && wr_acc && in_range) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.byteenable[i]) mem[word_addr][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  // Idle stages carry zero data so readdata is 0 whenever readdatavalid is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_dat[0] <= rd_acc ? rd_word : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending  <= '0;
      rd_count <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      case ({rd_acc, bus.readdatavalid})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (rd_acc && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (wr_acc && wr_count != '1) wr_count <= wr_count + 1'b1;
      if ((wr_acc && (rd_req || !in_range)) || (rd_acc && !in_range)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Self-checking bench for avmm_mem_responder: scoreboard of expected read returns
// plus a second instance (READ_LATENCY=3, MAX_PENDING=1) for throttling.
module tb_avmm_mem_responder;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  avmm_mem_responder_if #(.DATA_W(16)) bus ();
  avmm_mem_responder_if #(.DATA_W(16)) bus3 ();
  logic [15:0] rd_count, wr_count, rd_count3, wr_count3;
  logic        err, err3;

  avmm_mem_responder #(.ADDR_W(8), .DATA_W(16), .READ_LATENCY(RL), .MAX_PENDING(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .rd_count(rd_count), .wr_count(wr_count), .err(err)
  );

  avmm_mem_responder #(.ADDR_W(8), .DATA_W(16), .READ_LATENCY(3), .MAX_PENDING(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3),
    .rd_count(rd_count3), .wr_count(wr_count3), .err(err3)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdv_seen = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] model_mem [256];
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic        exp_err = 1'b0;
  logic        m_rd, m_wr, m_oor, m_wr_ok;

  always @(posedge clk) cyc++;

  // Scoreboard: check returns, then record what the bus presents this cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      exp_rd  = 0;
      exp_wr  = 0;
      exp_err = 1'b0;
`ifdef MEM_INIT_PATTERN_EN
      for (int i = 0; i < 256; i++) model_mem[i] = 16'(i);
`endif
    end else begin
      checks++;
      if (bus.readdatavalid) begin
        rdv_seen++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rdv: readdatavalid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.readdata !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL read_return: readdata=%h at cycle %0d, required %h at cycle %0d",
                     bus.readdata, cyc, e.data, e.due);
          end
        end
      end else if (bus.readdata !== 16'h0000) begin
        errors++;
        $display("FAIL idle_readdata: readdata=%h with readdatavalid=0, required 0000", bus.readdata);
      end
      m_rd  = bus.chipselect & ~bus.read_n;
      m_wr  = bus.chipselect & ~bus.write_n;
      m_oor = (bus.address[31:8] != 24'h0);
`ifdef MEM_INIT_PATTERN_EN
      m_wr_ok = m_wr & ~bus.waitrequest;
`else
      m_wr_ok = m_wr;
`endif
      if (m_wr_ok) begin
        exp_wr++;
        if (m_rd || m_oor) exp_err = 1'b1;
        if (!m_oor) begin
          if (bus.byteenable[0]) model_mem[bus.address[7:0]][7:0]  = bus.writedata[7:0];
          if (bus.byteenable[1]) model_mem[bus.address[7:0]][15:8] = bus.writedata[15:8];
        end
      end else if (m_rd && !m_wr && !bus.waitrequest) begin
        exp_rd++;
        if (m_oor) exp_err = 1'b1;
        sb.push_back('{data: m_oor ? 16'hDEAD : model_mem[bus.address[7:0]], due: cyc + RL});
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [1:0] be, input logic [15:0] wd);
    bus.chipselect = rd | wr;
    bus.read_n     = ~rd;
    bus.write_n    = ~wr;
    bus.address    = addr;
    bus.byteenable = be;
    bus.writedata  = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.chipselect  = 1'b0;
    bus.read_n      = 1'b1;
    bus.write_n     = 1'b1;
    bus3.chipselect = 1'b0;
    bus3.read_n     = 1'b1;
    bus3.write_n    = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(output logic ok);
    int t = 0;
    while (sb.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    ok = (sb.size() == 0);
  endtask

  task automatic wait_init;
`ifdef MEM_INIT_PATTERN_EN
    int n = 0;
    while (bus.waitrequest && n < 300) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL init_wait: waitrequest high for %0d cycles, required 256", n);
    end
`endif
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(3);
    checks++;
`ifdef MEM_INIT_PATTERN_EN
    if (bus.waitrequest !== 1'b1 || bus.readdatavalid !== 1'b0 || bus.readdata !== 16'h0
`else
    if (bus.waitrequest !== 1'b0 || bus.readdatavalid !== 1'b0 || bus.readdata !== 16'h0
`endif
        || rd_count !== 16'h0 || wr_count !== 16'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: wr=%b rdv=%b rd=%h rc=%h wc=%h err=%b, required idle/zero",
               bus.waitrequest, bus.readdatavalid, bus.readdata, rd_count, wr_count, err);
    end
    reset_n = 1'b1;
    wait_init();
  endtask

  task automatic test_init_pattern;
    logic ok;
    drive(1'b1, 1'b0, 32'd9, 2'b00, 16'h0);
    drive(1'b1, 1'b0, 32'd255, 2'b00, 16'h0);
    idle(1);
    drain(ok);
    checks++;
    if (!ok || model_mem[9] !== 16'h0009) begin
      errors++;
      $display("FAIL init_pattern: drained=%b, required 1 with mem[9]=0009", ok);
    end
  endtask

  task automatic test_write_read;
    logic ok;
    int   rc0 = exp_rd, wc0 = exp_wr;
    drive(1'b0, 1'b1, 32'd3, 2'b11, 16'hBEEF);
    drive(1'b1, 1'b0, 32'd3, 2'b00, 16'h0);
    idle(1);
    drain(ok);
    checks++;
    if (!ok || rd_count !== 16'(rc0 + 1) || wr_count !== 16'(wc0 + 1)) begin
      errors++;
      $display("FAIL write_read: drained=%b rd_count=%0d wr_count=%0d, required 1 %0d %0d",
               ok, rd_count, wr_count, rc0 + 1, wc0 + 1);
    end
  endtask

  task automatic test_byte_enable;
    logic ok;
    drive(1'b0, 1'b1, 32'd3, 2'b01, 16'h1234);
    drive(1'b1, 1'b0, 32'd3, 2'b00, 16'h0);
    drive(1'b0, 1'b1, 32'd3, 2'b10, 16'h77AA);
    drive(1'b1, 1'b0, 32'd3, 2'b00, 16'h0);
    drive(1'b0, 1'b1, 32'd3, 2'b00, 16'hFFFF);
    drive(1'b1, 1'b0, 32'd3, 2'b00, 16'h0);
    idle(1);
    drain(ok);
    checks++;
    if (!ok || model_mem[3] !== 16'h7734) begin
      errors++;
      $display("FAIL byte_enable: drained=%b, required 1 with final word 7734", ok);
    end
  endtask

  task automatic test_back_to_back;
    logic ok;
    int   seen0, rc0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32'(i), 2'b11, 16'($urandom));
    seen0 = rdv_seen;
    rc0   = exp_rd;
    for (int i = 0; i < 10; i++) begin
      bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.write_n = 1'b1; bus.address = 32'(i);
      checks++;
      if (bus.waitrequest !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall: waitrequest=%b on read %0d, required 0", bus.waitrequest, i);
      end
      @(posedge clk); #1;
    end
    idle(1);
    drain(ok);
    checks++;
    if (!ok || rdv_seen - seen0 != 10 || rd_count !== 16'(rc0 + 10)) begin
      errors++;
      $display("FAIL b2b_count: returns=%0d rd_count=%0d, required 10 and %0d",
               rdv_seen - seen0, rd_count, rc0 + 10);
    end
  endtask

  task automatic test_out_of_range;
    logic ok;
    drive(1'b0, 1'b1, 32'd0, 2'b11, 16'hA5A5);
    drive(1'b0, 1'b1, 32'd255, 2'b11, 16'h0FF0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_early: err=%b, required 0", err);
    end
    drive(1'b1, 1'b0, 32'h0000_0100, 2'b00, 16'h0);
    drive(1'b0, 1'b1, 32'h0000_0100, 2'b11, 16'h5555);
    drive(1'b0, 1'b1, 32'h8000_0000, 2'b11, 16'h6666);
    drive(1'b1, 1'b0, 32'd0, 2'b00, 16'h0);
    drive(1'b1, 1'b0, 32'h0001_0003, 2'b00, 16'h0);
    drive(1'b1, 1'b0, 32'd255, 2'b00, 16'h0);
    idle(1);
    drain(ok);
    checks++;
    if (!ok || err !== 1'b1 || err !== exp_err) begin
      errors++;
      $display("FAIL out_of_range: drained=%b err=%b, required 1 and 1", ok, err);
    end
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 1'b0, 32'd1, 2'b00, 16'h0);
    drive(1'b1, 1'b0, 32'd2, 2'b00, 16'h0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    wait_init();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.readdatavalid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_rdv: readdatavalid=%b %0d cycles after reset, required 0",
                 bus.readdatavalid, i);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0 || err !== 1'b0 || rd_count3 !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_state: rc=%h wc=%h err=%b rc3=%h, required 0 0 0 0",
               rd_count, wr_count, err, rd_count3);
    end
  endtask

  task automatic test_simultaneous;
    logic ok;
    drive(1'b1, 1'b1, 32'd5, 2'b11, 16'h7777);
    drive(1'b1, 1'b0, 32'd5, 2'b00, 16'h0);
    idle(1);
    drain(ok);
    checks++;
    if (!ok || err !== 1'b1 || rd_count !== 16'd1 || wr_count !== 16'd1 || model_mem[5] !== 16'h7777) begin
      errors++;
      $display("FAIL simultaneous: err=%b rc=%0d wc=%0d, required 1 1 1", err, rd_count, wr_count);
    end
  endtask

  task automatic test_throttle;
    bus3.chipselect = 1'b1; bus3.read_n = 1'b1; bus3.write_n = 1'b0;
    bus3.address = 32'd0; bus3.byteenable = 2'b11; bus3.writedata = 16'h4242;
    @(posedge clk); #1;
    bus3.read_n = 1'b0; bus3.write_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus3.waitrequest !== (i % 3 != 0)) begin
        errors++;
        $display("FAIL throttle_wait: waitrequest=%b at step %0d, required %b",
                 bus3.waitrequest, i, (i % 3 != 0));
      end
      checks++;
      if (bus3.readdatavalid !== (i % 3 == 0 && i > 0) ||
          (bus3.readdatavalid === 1'b1 && bus3.readdata !== 16'h4242)) begin
        errors++;
        $display("FAIL throttle_rdv: rdv=%b data=%h at step %0d, required %b with 4242",
                 bus3.readdatavalid, bus3.readdata, i, (i % 3 == 0 && i > 0));
      end
      @(posedge clk); #1;
    end
    idle(4);
    checks++;
    if (rd_count3 !== 16'd4 || wr_count3 !== 16'd1) begin
      errors++;
      $display("FAIL throttle_count: rd_count=%0d wr_count=%0d, required 4 1", rd_count3, wr_count3);
    end
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.address = '0; bus.byteenable = '0; bus.writedata = '0;
    bus3.chipselect = 1'b0; bus3.read_n = 1'b1; bus3.write_n = 1'b1;
    bus3.address = '0; bus3.byteenable = '0; bus3.writedata = '0;
    #1;
    test_reset();
`ifdef MEM_INIT_PATTERN_EN
    test_init_pattern();
`endif
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_throttle();
    test_reset_midflight();
    test_simultaneous();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
